// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the sequential PC increment.
package fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } fetch_state_e;

  // Byte distance between consecutive instructions
  localparam int unsigned C_PC_INCR = 4;

endpackage : fetch_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction
// memory and holds the fetched instruction in an inline IF/ID register with a
// valid/ready handshake. Redirects have top priority and squash the
// in-flight instruction.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target raises a sticky
//               o_misalign and freezes fetch in S_TRAP until reset.
//   undefined : redirect target bits [1:0] are forced to zero and
//               o_misalign is tied low.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   o_imem_addr         byte address to instruction memory (current PC)
//   i_imem_instr        instruction returned for o_imem_addr
//   i_redirect_valid    replace the PC with i_redirect_pc
//   i_redirect_pc       redirect target byte address
//   o_valid / i_ready   IF/ID handshake
//   o_instr, o_pc       registered instruction and its byte address
//   o_pc_plus4          o_pc + 4 (wrapping)
//   o_misalign          sticky misaligned-redirect trap flag
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 10,
  parameter int unsigned P_RESET_PC   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic [P_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [P_DATA_WIDTH-1:0] i_imem_instr,
  input  logic                    i_redirect_valid,
  input  logic [P_ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [P_DATA_WIDTH-1:0] o_instr,
  output logic [P_ADDR_WIDTH-1:0] o_pc,
  output logic [P_ADDR_WIDTH-1:0] o_pc_plus4,
  output logic                    o_misalign
);

  localparam logic [P_ADDR_WIDTH-1:0] C_RESET_PC   = P_ADDR_WIDTH'(P_RESET_PC);
  localparam logic [P_ADDR_WIDTH-1:0] C_INCR       = P_ADDR_WIDTH'(C_PC_INCR);
  localparam logic [P_ADDR_WIDTH-1:0] C_ALIGN_MASK = ~P_ADDR_WIDTH'(3);

  fetch_state_e              r_state;
  logic [P_ADDR_WIDTH-1:0]   r_pc;
  logic                      r_valid;
  logic [P_DATA_WIDTH-1:0]   r_instr;
  logic [P_ADDR_WIDTH-1:0]   r_pc_out;
  logic [P_ADDR_WIDTH-1:0]   r_pc_plus4;

  fetch_state_e              w_state_nxt;
  logic [P_ADDR_WIDTH-1:0]   w_pc_nxt;
  logic                      w_valid_nxt;
  logic [P_DATA_WIDTH-1:0]   w_instr_nxt;
  logic [P_ADDR_WIDTH-1:0]   w_pc_out_nxt;
  logic [P_ADDR_WIDTH-1:0]   w_pc_plus4_nxt;
  logic [P_ADDR_WIDTH-1:0]   w_pc_inc;
  logic                      w_misalign_nxt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                      r_misalign;
`endif

  // Sequential successor of the PC; wraps naturally at the address width
  assign w_pc_inc = r_pc + C_INCR;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_valid;
    w_instr_nxt    = r_instr;
    w_pc_out_nxt   = r_pc_out;
    w_pc_plus4_nxt = r_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misalign_nxt = r_misalign;
`else
    w_misalign_nxt = 1'b0;
`endif
    case (r_state)
      S_BOOT: begin
        // One idle cycle after reset; redirects are ignored here
        w_state_nxt = S_RUN;
        w_valid_nxt = 1'b0;
      end
      S_RUN: begin
        if (i_redirect_valid) begin
          // Squash the in-flight instruction whatever i_ready says
          w_valid_nxt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (i_redirect_pc[1:0] != 2'b00) begin
            w_misalign_nxt = 1'b1;
            w_state_nxt    = S_TRAP;
          end else begin
            w_pc_nxt = i_redirect_pc & C_ALIGN_MASK;
          end
`else
          w_pc_nxt = i_redirect_pc & C_ALIGN_MASK;
`endif
        end else if (!r_valid || i_ready) begin
          w_valid_nxt    = 1'b1;
          w_instr_nxt    = i_imem_instr;
          w_pc_out_nxt   = r_pc;
          w_pc_plus4_nxt = w_pc_inc;
          w_pc_nxt       = w_pc_inc;
        end
      end
      S_TRAP: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_BOOT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and IF/ID register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= C_RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc_out   <= '0;
      r_pc_plus4 <= C_INCR;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_pc_out   <= w_pc_out_nxt;
      r_pc_plus4 <= w_pc_plus4_nxt;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky trap flag, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_nxt;
    end
  end

  assign o_misalign = r_misalign;
`else
  assign o_misalign = w_misalign_nxt;
`endif

  assign o_imem_addr = r_pc;
  assign o_valid     = r_valid;
  assign o_instr     = r_instr;
  assign o_pc        = r_pc_out;
  assign o_pc_plus4  = r_pc_plus4;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized handshake/redirect traffic checked every cycle
// against an instruction-stream model.
module tb_fetch_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic [AW-1:0] o_imem_addr;
  logic [DW-1:0] i_imem_instr;
  logic          i_redirect_valid = 1'b0;
  logic [AW-1:0] i_redirect_pc = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_pc;
  logic [AW-1:0] o_pc_plus4;
  logic          o_misalign;

  logic [DW-1:0] mem [256];
  assign i_imem_instr = mem[o_imem_addr[AW-1:2]];

  fetch_unit #(
    .P_DATA_WIDTH(DW),
    .P_ADDR_WIDTH(AW),
    .P_RESET_PC  (0)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .o_imem_addr     (o_imem_addr),
    .i_imem_instr    (i_imem_instr),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .o_pc_plus4      (o_pc_plus4),
    .o_misalign      (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream model: booting -> running -> (trapped). While running, the unit
  // delivers the instruction at "next fetch address" whenever its output slot
  // is empty or being consumed; a redirect empties the slot and restarts the
  // stream at the (word-aligned) target.
  int            m_phase = 0;   // 0 booting, 1 running, 2 trapped
  logic [AW-1:0] m_fetch = '0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_pc    = '0;
  logic [DW-1:0] m_instr = '0;
  logic          m_mis   = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_phase <= 0;
      m_fetch <= '0;
      m_valid <= 1'b0;
      m_pc    <= '0;
      m_instr <= '0;
      m_mis   <= 1'b0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      if (i_redirect_valid) begin
        m_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (i_redirect_pc % 4 != 0) begin
          m_mis   <= 1'b1;
          m_phase <= 2;
        end else begin
          m_fetch <= i_redirect_pc;
        end
`else
        m_fetch <= AW'((i_redirect_pc / 4) * 4);
`endif
      end else if (!m_valid || i_ready) begin
        m_valid <= 1'b1;
        m_pc    <= m_fetch;
        m_instr <= mem[m_fetch / 4];
        m_fetch <= AW'((32'(m_fetch) + 4) % 1024);
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("m_valid", 64'(o_valid), 64'(m_valid));
      chk("m_pc", 64'(o_pc), 64'(m_pc));
      chk("m_instr", 64'(o_instr), 64'(m_instr));
      chk("m_pc_plus4", 64'(o_pc_plus4), 64'((32'(m_pc) + 4) % 1024));
      chk("m_imem_addr", 64'(o_imem_addr), 64'(m_fetch));
      chk("m_misalign", 64'(o_misalign), 64'(m_mis));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_pc"}, 64'(o_pc), 64'(0));
    chk({tag, "_instr"}, 64'(o_instr), 64'(0));
    chk({tag, "_misalign"}, 64'(o_misalign), 64'(0));
    chk({tag, "_imem_addr"}, 64'(o_imem_addr), 64'(0));
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;

    // Reset and release
    #2 i_rst_n = 1'b0;
    #1 chk_reset_vals("rst");
    cmp_en = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // First instruction two edges after release
    @(negedge i_clk);
    chk("boot_valid", 64'(o_valid), 64'(0));
    @(negedge i_clk);
    chk("first_valid", 64'(o_valid), 64'(1));
    chk("first_instr", 64'(o_instr), 64'h0050_0093);
    chk("first_pc", 64'(o_pc), 64'(0));
    @(negedge i_clk);
    chk("second_pc", 64'(o_pc), 64'(4));

    // Three-cycle stall at pc 0x008
    @(negedge i_clk);
    chk("pre_stall_pc", 64'(o_pc), 64'h008);
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("stall_pc", 64'(o_pc), 64'h008);
      chk("stall_instr", 64'(o_instr), 64'(mem[2]));
      chk("stall_addr", 64'(o_imem_addr), 64'h00C);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("post_stall_pc", 64'(o_pc), 64'h00C);

    // Redirect during a stall wins
    i_ready = 1'b0;
    i_redirect_valid = 1'b1;
    i_redirect_pc = 10'h040;
    @(negedge i_clk);
    chk("redir_squash_valid", 64'(o_valid), 64'(0));
    i_redirect_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("redir_target_valid", 64'(o_valid), 64'(1));
    chk("redir_target_pc", 64'(o_pc), 64'h040);
    chk("redir_target_instr", 64'(o_instr), 64'(mem[16]));

    // Wrap at the top of the address space
    i_redirect_valid = 1'b1;
    i_redirect_pc = 10'h3F8;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    @(negedge i_clk);
    chk("wrap_pc0", 64'(o_pc), 64'h3F8);
    @(negedge i_clk);
    chk("wrap_pc1", 64'(o_pc), 64'h3FC);
    chk("wrap_plus4", 64'(o_pc_plus4), 64'h000);
    @(negedge i_clk);
    chk("wrap_pc2", 64'(o_pc), 64'h000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clk);
      i_ready = ($urandom_range(0, 3) != 0);
      i_redirect_valid = ($urandom_range(0, 11) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      i_redirect_pc = AW'($urandom) & ~AW'(3);
`else
      i_redirect_pc = AW'($urandom);
`endif
    end
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    i_ready = 1'b1;

    // Asynchronous reset mid-stream at pc 0x020
    i_redirect_valid = 1'b1;
    i_redirect_pc = 10'h010;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge i_clk);
      if (o_valid && o_pc == 10'h020) found = 1'b1;
    end
    chk("reach_pc_020", 64'(found), 64'(1));
    #2 i_rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge i_clk);
    // Redirect held through the boot cycle must be ignored
    i_redirect_valid = 1'b1;
    i_redirect_pc = 10'h100;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("boot2_valid", 64'(o_valid), 64'(0));
    i_redirect_valid = 1'b0;
    @(negedge i_clk);
    chk("boot2_valid1", 64'(o_valid), 64'(1));
    chk("boot2_pc", 64'(o_pc), 64'(0));

    // Misaligned redirect
    i_redirect_valid = 1'b1;
    i_redirect_pc = 10'h042;
    @(negedge i_clk);
    i_redirect_valid = 1'b0;
    chk("mis_squash_valid", 64'(o_valid), 64'(0));
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      chk("trap_valid", 64'(o_valid), 64'(0));
      chk("trap_misalign", 64'(o_misalign), 64'(1));
    end
    i_rst_n = 1'b0;
    #1 chk("trap_rst_misalign", 64'(o_misalign), 64'(0));
`else
    @(negedge i_clk);
    chk("mis_resume_valid", 64'(o_valid), 64'(1));
    chk("mis_resume_pc", 64'(o_pc), 64'h040);
    chk("mis_flag", 64'(o_misalign), 64'(0));
`endif
    @(negedge i_clk);
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter P_DATA_WIDTH, default 32, instruction width.
REQ-002 The block SHALL have parameter P_ADDR_WIDTH, default 10, byte-address width of the instruction space.
REQ-003 The block SHALL have parameter P_RESET_PC, default 0, PC value loaded on reset; word-aligned.
REQ-004 i_clk  input  1  single clock; all state on the rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 o_imem_addr  output  P_ADDR_WIDTH  byte address to the combinational instruction memory.
REQ-007 i_imem_instr  input  P_DATA_WIDTH  instruction returned combinationally for o_imem_addr.
REQ-008 i_redirect_valid  input  1  branch/jump taken; replace the PC.
REQ-009 i_redirect_pc  input  P_ADDR_WIDTH  redirect target byte address.
REQ-010 o_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 i_ready  input  1  downstream accepts the IF/ID contents this cycle.
REQ-012 o_instr  output  P_DATA_WIDTH  registered instruction.
REQ-013 o_pc  output  P_ADDR_WIDTH  byte address of o_instr.
REQ-014 o_pc_plus4  output  P_ADDR_WIDTH  o_pc + 4, modulo 2^P_ADDR_WIDTH.
REQ-015 o_misalign  output  1  sticky misaligned-redirect trap flag (macro-dependent).

Function
REQ-016 o_imem_addr SHALL equal the internal PC register combinationally, with no added latency.
REQ-017 FSM states SHALL be S_BOOT, S_RUN and S_TRAP; reset enters S_BOOT.
REQ-018 S_BOOT SHALL last exactly one cycle with o_valid=0, no fetch and no PC change, then go to S_RUN.
REQ-019 In S_RUN, "load" SHALL occur when o_valid=0 or (o_valid=1 and i_ready=1).
REQ-020 On load, o_instr<=i_imem_instr, o_pc<=PC, o_valid<=1 and PC<=PC+4; instruction latency is one cycle.
REQ-021 When o_valid=1 and i_ready=0, o_instr, o_pc, o_valid and PC SHALL hold.
REQ-022 PC+4 SHALL wrap modulo 2^P_ADDR_WIDTH, so 0x3FC is followed by 0x000 at default width.
REQ-023 i_redirect_valid SHALL have top priority in S_RUN: PC<=i_redirect_pc, o_valid<=0, and the in-flight instruction is discarded regardless of i_ready.
REQ-024 After a redirect, the first instruction from the target SHALL be valid on the second edge after the redirect.
REQ-025 If a redirect and a stall occur in the same cycle, the redirect wins.
REQ-026 i_redirect_valid in S_BOOT SHALL be ignored.
REQ-027 S_TRAP SHALL hold o_valid=0 and a frozen PC until reset.

Reset
REQ-028 Asserting i_rst_n low at any time, including mid-stall or mid-redirect, SHALL immediately force PC=P_RESET_PC, o_valid=0, o_instr=0, o_pc=0, o_misalign=0 and state S_BOOT.
REQ-029 After deassertion, the first valid instruction SHALL be the one at P_RESET_PC, two edges later.

Configuration
REQ-030 With FETCH_MISALIGN_TRAP_EN defined, a redirect with i_redirect_pc[1:0]!=0 SHALL set o_misalign=1, leave PC unchanged, clear o_valid, and enter S_TRAP.
REQ-031 Without FETCH_MISALIGN_TRAP_EN, i_redirect_pc[1:0] SHALL be forced to 0, o_misalign SHALL be tied 0, and S_TRAP is unreachable.

Structure
REQ-032 A shared package fetch_pkg SHALL hold the FSM state enum (fetch_state_e) and the constant C_PC_INCR=4.
REQ-033 The block SHALL be a single module with no sub-modules; the IF/ID register is inline.

Verification
REQ-034 Reset release with P_RESET_PC=0 and imem[0]=0x00500093 -> o_valid=1, o_instr=0x00500093, o_pc=0 on the 2nd edge, then o_pc=4 on the next edge.
REQ-035 i_ready=0 for 3 cycles at o_pc=0x008 -> o_instr, o_pc and o_imem_addr=0x00C stable all 3 cycles; o_pc=0x00C one edge after i_ready=1.
REQ-036 Redirect to 0x040 while o_valid=1 and i_ready=0 -> o_valid=0 next cycle; o_pc=0x040 valid the cycle after.
REQ-037 Straight-line fetch from 0x3F8 -> o_pc sequence 0x3F8, 0x3FC, 0x000, with o_pc_plus4=0x000 when o_pc=0x3FC.
REQ-038 With the macro, redirect to 0x042 -> o_misalign=1 and o_valid stuck at 0 until i_rst_n; without the macro -> fetch resumes at 0x040.
REQ-039 i_rst_n asserted mid-stream at o_pc=0x020 -> all outputs at reset values in the same cycle, with no clock edge required.
